unified_mem_arbiter: RTL
========================

Name: unified_mem_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between the IF-stage instruction fetch port and the MEM-stage load/store port of the 5-stage MIPS pipeline.
- Sequences each access through a small FSM.
- Arbitrates with data-priority plus fetch anti-starvation.
- Emits stall signals that freeze PC and the pipeline registers while an access is outstanding.

Parameters:
- MEM_LAT, 2, memory read latency in cycles; legal range 1..15.
- ADDR_W, 10, memory word-address width; low bits of the 30-bit word address.
- STARVE_MAX, 2, consecutive fetch losses after which fetch wins the next arbitration; legal range 1..7.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- if_req  in  1  fetch request; held until if_done.
- if_addr  in  30  fetch word address, PC[31:2].
- if_rdata  out  32  fetched instruction; registered.
- if_done  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request; held until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  30  data word address, alu_result[31:2].
- d_wdata  in  32  store data.
- d_rdata  out  32  load data; registered.
- d_done  out  1  one-cycle completion pulse for data.
- m_en  out  1  memory access enable.
- m_we  out  1  memory write enable.
- m_addr  out  ADDR_W  memory word address.
- m_wdata  out  32  memory write data.
- m_rdata  in  32  memory read data; valid MEM_LAT cycles after m_en rises with address held stable.
- if_stall  out  1  if_req & ~if_done; combinational.
- d_stall  out  1  d_req & ~d_done; combinational.
- pipe_stall  out  1  if_stall | d_stall; freezes PC and the if_id, id_ex, ex_mem and mem_wr registers.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; cnt, starve, owner cleared.
  - if_rdata = d_rdata = 0; if_done = d_done = 0.
  - m_en = m_we = 0; m_addr = m_wdata = 0.
  - An in-flight access is aborted and m_we drops immediately.
  - Requests are ignored while rst is low.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Only one requester: grant it.
  - Both requesters: grant data if starve < STARVE_MAX, else grant fetch.
  - On grant, at the clock edge: latch owner, addr[ADDR_W-1:0], we (forced to 0 for fetch) and wdata; cnt = 0; go to ACCESS.
- starve counter (3 bits, saturating):
  - +1 when fetch requests in IDLE and loses.
  - Cleared when fetch is granted, or when if_req is low in IDLE.
- ACCESS:
  - m_en = 1; m_addr, m_we, m_wdata driven from the latched values, stable for the whole state.
  - cnt increments each cycle.
  - When cnt == MEM_LAT-1: capture m_rdata into the owner's rdata register (loads and fetches only; a store leaves d_rdata unchanged); go to DONE.
  - ACCESS therefore lasts exactly MEM_LAT cycles.
- DONE:
  - m_en = m_we = 0.
  - The owner's done is high for exactly this cycle; rdata is valid from this cycle and held until overwritten.
  - Next state is IDLE, unconditionally.
- Latency: a request sampled in IDLE at cycle t gives done at cycle t+MEM_LAT+1. Back-to-back accesses are MEM_LAT+2 cycles apart.
- Requester behaviour: the requester drops or changes its req at the edge ending the done cycle. A requester releasing req mid-access does not abort the access; done still pulses and is ignored.
- Address, we and wdata are sampled only at grant; later changes have no effect on the current access.
- if_done and d_done are never high in the same cycle.
- At most one access is outstanding.
- Addresses wrap modulo 2^ADDR_W words; upper address bits are ignored.

Test Plan:
- MEM_LAT=2; if_req=1, if_addr=0x3, mem[3]=0x8C010004 at cycle 0 -> m_en high cycles 1-2, m_addr=3; if_done pulses cycle 3 with if_rdata=0x8C010004; if_stall high cycles 0-2.
- Store d_we=1, d_addr=0x5, d_wdata=0xDEADBEEF at cycle 0, then load d_addr=0x5 at cycle 4 -> m_we high cycles 1-2 only; d_done at cycles 3 and 7; d_rdata=0xDEADBEEF at cycle 7; d_rdata unchanged at cycle 3.
- if_req and d_req both held continuously, STARVE_MAX=2, MEM_LAT=2 -> data granted at cycles 0 and 4 (starve goes 1, then 2); fetch granted at cycle 8 with if_done at cycle 11; starve=0 afterwards; the pattern repeats.
- Simultaneous requests with starve=0 -> data wins; if_stall and pipe_stall stay high until if_done.
- rst driven low mid-ACCESS during a store at cycle 1 -> m_en, m_we and the done signals go to 0 immediately with no clock edge; after release with no requests, state stays IDLE and nothing pulses.
- MEM_LAT=1; d_addr=0x405 with ADDR_W=10 -> m_addr=0x005; d_done 2 cycles after the request.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
//   Shares one single-port, fixed-latency unified memory between the IF-stage
//   fetch port and the MEM-stage load/store port. One access is outstanding at
//   a time, sequenced IDLE -> ACCESS (MEM_LAT cycles) -> DONE. Data wins ties
//   unless fetch has lost STARVE_MAX arbitrations in a row.
//
// Ports
//   clk, rst                      clock, asynchronous active-low reset
//   if_req/if_addr                fetch request (held until if_done), word address
//   if_rdata/if_done              registered instruction, one-cycle done pulse
//   d_req/d_we/d_addr/d_wdata     data request (held until d_done)
//   d_rdata/d_done                registered load data, one-cycle done pulse
//   m_en/m_we/m_addr/m_wdata      memory command, stable for the whole access
//   m_rdata                       memory read data, valid MEM_LAT cycles into the access
//   if_stall/d_stall/pipe_stall   combinational pipeline freeze

// Per-port response slice: read-data register, done pulse and stall.
module uma_port_rsp (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        sel,      // this port owns the current access
    input  logic        cap,      // last ACCESS cycle of a read
    input  logic        in_done,  // arbiter is in DONE
    input  logic [31:0] m_rdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        stall
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            rdata <= '0;
        else if (cap && sel) rdata <= m_rdata;
    end

    assign done  = in_done & sel;
    assign stall = req & ~done;
endmodule

module unified_mem_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int ADDR_W     = 10,
    parameter int STARVE_MAX = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [29:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [29:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_done,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata,
    output logic              if_stall,
    output logic              d_stall,
    output logic              pipe_stall
);
    localparam int NUM_PORTS = 2;
    localparam int P_IF      = 0;
    localparam int P_D       = 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
    } acc_t;

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic [2:0] starve;
    logic       owner;      // 1 = data port, 0 = fetch port
    acc_t       acc, acc_nxt;

    logic grant_d, grant_if, grant, last_beat, cap, in_done;

    logic [NUM_PORTS-1:0]       req, sel, done, stall;
    logic [NUM_PORTS-1:0][31:0] rdata;

    // Data wins ties until fetch has lost STARVE_MAX arbitrations in a row.
    assign grant_d  = d_req && (!if_req || (starve < 3'(STARVE_MAX)));
    assign grant_if = if_req && !grant_d;
    assign grant    = grant_d || grant_if;

    assign last_beat = (state == ACCESS) && (cnt == 4'(MEM_LAT - 1));
    assign cap       = last_beat && !acc.we;
    assign in_done   = (state == DONE);

    // Command fields captured at grant; fetches never write.
    assign acc_nxt.we    = grant_d && d_we;
    assign acc_nxt.addr  = grant_d ? d_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0];
    assign acc_nxt.wdata = d_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = ACCESS;
            ACCESS:  if (last_beat) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            starve <= '0;
            owner  <= 1'b0;
            acc    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Only fetch losses that actually happen in IDLE count.
                    if (if_req && !grant_if)
                        starve <= (starve == 3'd7) ? starve : starve + 3'd1;
                    else
                        starve <= '0;
                    if (grant) begin
                        owner <= grant_d;
                        acc   <= acc_nxt;
                        cnt   <= '0;
                    end
                end
                ACCESS:  cnt <= cnt + 4'd1;
                default: ;
            endcase
        end
    end

    // Command outputs derive from state so an async reset drops them at once.
    assign m_en    = (state == ACCESS);
    assign m_we    = m_en && acc.we;
    assign m_addr  = acc.addr;
    assign m_wdata = acc.wdata;

    assign req           = {d_req, if_req};
    assign sel[P_IF]     = !owner;
    assign sel[P_D]      = owner;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        uma_port_rsp u_rsp (
            .clk     (clk),
            .rst     (rst),
            .req     (req[p]),
            .sel     (sel[p]),
            .cap     (cap),
            .in_done (in_done),
            .m_rdata (m_rdata),
            .rdata   (rdata[p]),
            .done    (done[p]),
            .stall   (stall[p])
        );
    end

    assign if_rdata   = rdata[P_IF];
    assign d_rdata    = rdata[P_D];
    assign if_done    = done[P_IF];
    assign d_done     = done[P_D];
    assign if_stall   = stall[P_IF];
    assign d_stall    = stall[P_D];
    assign pipe_stall = |stall;

    // Upper word-address bits are ignored: memory wraps modulo 2^ADDR_W.
    if (ADDR_W < 30) begin : g_unused
        logic unused_addr_hi;
        assign unused_addr_hi = ^{if_addr[29:ADDR_W], d_addr[29:ADDR_W]};
    end
endmodule
